// File: rtl/pic_ctrl_pkg.sv
// Shared definitions for the PIC16F84 program-flow controller:
// default widths, control-flow opcode match masks/values, FSM states,
// and the opcode classifier used by the sequencer.
package pic_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF      = 10;
  localparam int unsigned INSTR_W_DEF     = 14;
  localparam int unsigned STACK_DEPTH_DEF = 8;

  // Opcode match: (ir & MASK) == VAL
  localparam logic [13:0] GOTO_MASK   = 14'h3800;
  localparam logic [13:0] GOTO_VAL    = 14'h2800;  // 10_1kkk
  localparam logic [13:0] CALL_MASK   = 14'h3800;
  localparam logic [13:0] CALL_VAL    = 14'h2000;  // 10_0kkk
  localparam logic [13:0] RETURN_VAL  = 14'h0008;  // exact match
  localparam logic [13:0] RETFIE_VAL  = 14'h0009;  // exact match
  localparam logic [13:0] RETLW_MASK  = 14'h3C00;
  localparam logic [13:0] RETLW_VAL   = 14'h3400;  // 11_01xx
  localparam logic [13:0] FSZ_MASK    = 14'h3F00;
  localparam logic [13:0] DECFSZ_VAL  = 14'h0B00;  // 00_1011
  localparam logic [13:0] INCFSZ_VAL  = 14'h0F00;  // 00_1111
  localparam logic [13:0] BTFS_MASK   = 14'h3C00;
  localparam logic [13:0] BTFSC_VAL   = 14'h1800;  // 01_10
  localparam logic [13:0] BTFSS_VAL   = 14'h1C00;  // 01_11

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_e;

  typedef enum logic [2:0] {
    OP_PLAIN  = 3'd0,
    OP_GOTO   = 3'd1,
    OP_CALL   = 3'd2,
    OP_RETURN = 3'd3,
    OP_RETLW  = 3'd4,
    OP_SKIP   = 3'd5
  } op_class_e;

  // Classify an instruction word by its control-flow effect.
  function automatic op_class_e decode_op(input logic [13:0] ir);
    op_class_e c;
    c = OP_PLAIN;
    if ((ir & GOTO_MASK) == GOTO_VAL)
      c = OP_GOTO;
    else if ((ir & CALL_MASK) == CALL_VAL)
      c = OP_CALL;
    else if ((ir == RETURN_VAL) || (ir == RETFIE_VAL))
      c = OP_RETURN;
    else if ((ir & RETLW_MASK) == RETLW_VAL)
      c = OP_RETLW;
    else if (((ir & FSZ_MASK) == DECFSZ_VAL) || ((ir & FSZ_MASK) == INCFSZ_VAL) ||
             ((ir & BTFS_MASK) == BTFSC_VAL) || ((ir & BTFS_MASK) == BTFSS_VAL))
      c = OP_SKIP;
    return c;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Circular return-address stack (PIC semantics): sp wraps modulo depth,
// the depth counter saturates, overflow overwrites the oldest entry and
// underflow still pops. Push takes priority; the sequencer never issues both.
module pc_return_stack
  import pic_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int unsigned SP_W = $clog2(STACK_DEPTH);
  localparam logic [SP_W:0] FULL_CNT = (SP_W+1)'(STACK_DEPTH);

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q;
  logic [SP_W:0]     depth_q;
  logic              full;

  assign full        = (depth_q == FULL_CNT);
  assign empty_o     = (depth_q == '0);
  assign overflow_o  = push_i && full;
  assign underflow_o = pop_i && !push_i && empty_o;
  assign top_o       = mem_q[sp_q - SP_W'(1)];

  // Storage, pointer and saturating depth update on push/pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp_q    <= '0;
      depth_q <= '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i) begin
      mem_q[sp_q] <= push_addr_i;
      sp_q        <= sp_q + SP_W'(1);
      if (!full) begin
        depth_q <= depth_q + (SP_W+1)'(1);
      end
    end else if (pop_i) begin
      sp_q <= sp_q - SP_W'(1);
      if (!empty_o) begin
        depth_q <= depth_q - (SP_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/pc_flow_ctrl.sv
// Program-flow sequencer for the PIC16F84 core: FETCH/EXEC/FLUSH FSM,
// control-flow decode, PC enable generation and return-stack control.
// Optional feature macro: STACK_TRAP_EN (sticky stack_err on overflow or
// underflow; an underflowing return vectors to address 0 via goto_en).
module pc_flow_ctrl
  import pic_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned INSTR_W     = INSTR_W_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               stall,
  input  logic               skip_cond,
  input  logic [ADDR_W-1:0]  pc_ret_addr,
  output logic               pc_en,
  output logic               goto_en,
  output logic               call_en,
  output logic               ret_en,
  output logic               skip_en,
  output logic [ADDR_W-1:0]  pc_target,
  output logic [ADDR_W-1:0]  stack_top,
  output logic               retlw_valid,
  output logic               stack_err
);

  ctrl_state_e        state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  op_class_e          op;
  logic               push, pop, trap_vec, trap_pop;
  logic               stack_empty, stack_ovf, stack_unf;

  assign op = decode_op(ir_q);

  // ir stays valid through FLUSH, so the CALL push is keyed off the
  // decoded ir there instead of a separate pending flag.
  pc_return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .push_addr_i (pc_ret_addr),
    .top_o       (stack_top),
    .empty_o     (stack_empty),
    .overflow_o  (stack_ovf),
    .underflow_o (stack_unf)
  );

`ifdef STACK_TRAP_EN
  logic err_q;

  assign trap_pop  = stack_empty;
  assign stack_err = err_q;

  // Sticky stack fault flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (stack_ovf || stack_unf) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_stack_flags;

  assign trap_pop           = 1'b0;
  assign stack_err          = 1'b0;
  assign unused_stack_flags = ^{stack_empty, stack_ovf, stack_unf};
`endif

  assign pc_target = trap_vec ? '0 : ir_q[ADDR_W-1:0];

  // State and instruction register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, PC enables and stack control.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    instr_ready = 1'b0;
    pc_en       = 1'b0;
    goto_en     = 1'b0;
    call_en     = 1'b0;
    ret_en      = 1'b0;
    skip_en     = 1'b0;
    retlw_valid = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    trap_vec    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_d    = instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          pc_en   = 1'b1;
          state_d = ST_FETCH;
          case (op)
            OP_GOTO: begin
              goto_en = 1'b1;
              state_d = ST_FLUSH;
            end
            OP_CALL: begin
              call_en = 1'b1;
              state_d = ST_FLUSH;
            end
            OP_RETURN, OP_RETLW: begin
              pop         = 1'b1;
              retlw_valid = (op == OP_RETLW);
              if (trap_pop) begin
                goto_en  = 1'b1;
                trap_vec = 1'b1;
              end else begin
                ret_en = 1'b1;
              end
              state_d = ST_FLUSH;
            end
            OP_SKIP: begin
              skip_en = skip_cond;
            end
            default: begin
            end
          endcase
        end
      end
      ST_FLUSH: begin
        push    = (op == OP_CALL);
        state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed bench for pc_flow_ctrl: a per-cycle vector table for decode and
// FSM timing, plus hand sequences for reset, deep call/return and underflow.
module tb_pc_flow_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        stall = 1'b0;
  logic        skip_cond = 1'b0;
  logic [9:0]  pc_ret_addr = '0;
  logic        instr_ready, pc_en, goto_en, call_en, ret_en, skip_en, retlw_valid, stack_err;
  logic [9:0]  pc_target, stack_top;
  logic [6:0]  en_act;

  int unsigned total = 0;
  int unsigned bad   = 0;

  pc_flow_ctrl #(.ADDR_W(10), .INSTR_W(14), .STACK_DEPTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .stall       (stall),
    .skip_cond   (skip_cond),
    .pc_ret_addr (pc_ret_addr),
    .pc_en       (pc_en),
    .goto_en     (goto_en),
    .call_en     (call_en),
    .ret_en      (ret_en),
    .skip_en     (skip_en),
    .pc_target   (pc_target),
    .stack_top   (stack_top),
    .retlw_valid (retlw_valid),
    .stack_err   (stack_err)
  );

  always #5 clock = ~clock;

  // {ready, pc_en, goto, call, ret, skip, retlw}
  assign en_act = {instr_ready, pc_en, goto_en, call_en, ret_en, skip_en, retlw_valid};

  typedef struct {
    logic        vld;
    logic [13:0] ins;
    logic        stl;
    logic        skc;
    logic [9:0]  ret;
    logic [6:0]  exp_en;
    logic [9:0]  exp_tgt;
    logic        chk_top;
    logic [9:0]  exp_top;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(input logic v, input logic [13:0] i, input logic s, input logic k,
                              input logic [9:0] r, input logic [6:0] e, input logic [9:0] t,
                              input logic ct, input logic [9:0] tp);
    vec_t x;
    x.vld = v; x.ins = i; x.stl = s; x.skc = k; x.ret = r;
    x.exp_en = e; x.exp_tgt = t; x.chk_top = ct; x.exp_top = tp;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [13:0] i, input logic s, input logic k,
                       input logic [9:0] r);
    instr_valid = v; instr = i; stall = s; skip_cond = k; pc_ret_addr = r;
    #1;
  endtask

  task automatic adv();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_call(input logic [9:0] tgt, input logic [9:0] ret);
    logic [13:0] w;
    w = 14'h2000 | {4'b0000, tgt};
    drive(1'b1, w, 1'b0, 1'b0, ret);
    chk("call_fetch_en", en_act, 7'b1000000);
    adv();
    drive(1'b0, '0, 1'b0, 1'b0, ret);
    chk("call_exec_en", en_act, 7'b0101000);
    chk("call_exec_tgt", pc_target, tgt);
    adv();
    drive(1'b0, '0, 1'b0, 1'b0, ret);
    chk("call_flush_en", en_act, 7'b0000000);
    adv();
  endtask

  task automatic do_ret(input logic [9:0] exp_top);
    drive(1'b1, 14'h0008, 1'b0, 1'b0, '0);
    chk("ret_fetch_en", en_act, 7'b1000000);
    adv();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    chk("ret_exec_en", en_act, 7'b0100100);
    chk("ret_exec_top", stack_top, exp_top);
    adv();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    chk("ret_flush_en", en_act, 7'b0000000);
    adv();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // NOP stream, idle FETCH, stall ignored in FETCH
    vec.push_back(mk(1, 14'h0000, 0, 0, 0, 7'b1000000, 10'h000, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 0, 0, 7'b0100000, 10'h000, 0, 0));
    vec.push_back(mk(1, 14'h0000, 0, 0, 0, 7'b1000000, 10'h000, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 0, 0, 7'b0100000, 10'h000, 0, 0));
    vec.push_back(mk(1, 14'h0000, 1, 0, 0, 7'b1000000, 10'h000, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 0, 0, 7'b0100000, 10'h000, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 0, 0, 7'b1000000, 10'h000, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 0, 0, 7'b1000000, 10'h000, 0, 0));
    // GOTO 0x2A5; instr offered during FLUSH must not be captured
    vec.push_back(mk(1, 14'h2AA5, 0, 0, 0, 7'b1000000, 10'h000, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 0, 0, 7'b0110000, 10'h2A5, 0, 0));
    vec.push_back(mk(1, 14'h3FFF, 0, 0, 0, 7'b0000000, 10'h2A5, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 0, 0, 7'b1000000, 10'h2A5, 0, 0));
    // CALL 0x100 (ret 0x011) then RETURN
    vec.push_back(mk(1, 14'h2100, 0, 0, 10'h011, 7'b1000000, 10'h2A5, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 0, 10'h011, 7'b0101000, 10'h100, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 0, 10'h011, 7'b0000000, 10'h100, 0, 0));
    vec.push_back(mk(1, 14'h0008, 0, 0, 10'h3FF, 7'b1000000, 10'h100, 1, 10'h011));
    vec.push_back(mk(0, 14'h0000, 0, 0, 10'h3FF, 7'b0100100, 10'h008, 1, 10'h011));
    vec.push_back(mk(0, 14'h0000, 0, 0, 10'h3FF, 7'b0000000, 10'h008, 0, 0));
    // CALL 0x155 (ret 0x2AB) then RETFIE with a stalled EXEC
    vec.push_back(mk(1, 14'h2155, 0, 0, 10'h2AB, 7'b1000000, 10'h008, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 0, 10'h2AB, 7'b0101000, 10'h155, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 0, 10'h2AB, 7'b0000000, 10'h155, 0, 0));
    vec.push_back(mk(1, 14'h0009, 0, 0, 0, 7'b1000000, 10'h155, 1, 10'h2AB));
    vec.push_back(mk(0, 14'h0000, 1, 0, 0, 7'b0000000, 10'h009, 1, 10'h2AB));
    vec.push_back(mk(0, 14'h0000, 0, 0, 0, 7'b0100100, 10'h009, 1, 10'h2AB));
    vec.push_back(mk(0, 14'h0000, 0, 0, 0, 7'b0000000, 10'h009, 0, 0));
    // BTFSC taken / not taken
    vec.push_back(mk(1, 14'h1883, 0, 0, 0, 7'b1000000, 10'h009, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 1, 0, 7'b0100010, 10'h083, 0, 0));
    vec.push_back(mk(1, 14'h1883, 0, 0, 0, 7'b1000000, 10'h083, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 0, 0, 7'b0100000, 10'h083, 0, 0));
    // BTFSS held by stall for 3 cycles
    vec.push_back(mk(1, 14'h1C05, 0, 0, 0, 7'b1000000, 10'h083, 0, 0));
    vec.push_back(mk(0, 14'h0000, 1, 1, 0, 7'b0000000, 10'h005, 0, 0));
    vec.push_back(mk(0, 14'h0000, 1, 1, 0, 7'b0000000, 10'h005, 0, 0));
    vec.push_back(mk(0, 14'h0000, 1, 1, 0, 7'b0000000, 10'h005, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 1, 0, 7'b0100010, 10'h005, 0, 0));
    // DECFSZ taken, INCFSZ not taken, non-skip ops ignore skip_cond
    vec.push_back(mk(1, 14'h0B20, 0, 0, 0, 7'b1000000, 10'h005, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 1, 0, 7'b0100010, 10'h320, 0, 0));
    vec.push_back(mk(1, 14'h0F7F, 0, 0, 0, 7'b1000000, 10'h320, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 0, 0, 7'b0100000, 10'h37F, 0, 0));
    vec.push_back(mk(1, 14'h0800, 0, 0, 0, 7'b1000000, 10'h37F, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 1, 0, 7'b0100000, 10'h000, 0, 0));
    vec.push_back(mk(1, 14'h3A00, 0, 0, 0, 7'b1000000, 10'h000, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 1, 0, 7'b0100000, 10'h200, 0, 0));
    // Stalled GOTO; stall ignored in FLUSH
    vec.push_back(mk(1, 14'h2801, 0, 0, 0, 7'b1000000, 10'h200, 0, 0));
    vec.push_back(mk(0, 14'h0000, 1, 0, 0, 7'b0000000, 10'h001, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 0, 0, 7'b0110000, 10'h001, 0, 0));
    vec.push_back(mk(0, 14'h0000, 1, 0, 0, 7'b0000000, 10'h001, 0, 0));
    vec.push_back(mk(0, 14'h0000, 0, 0, 0, 7'b1000000, 10'h001, 0, 0));

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    chk("reset_en", en_act, 7'b1000000);
    chk("reset_tgt", pc_target, 10'h000);
    chk("reset_err", stack_err, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < vec.size(); i++) begin
      drive(vec[i].vld, vec[i].ins, vec[i].stl, vec[i].skc, vec[i].ret);
      chk($sformatf("vec%0d_en", i), en_act, vec[i].exp_en);
      chk($sformatf("vec%0d_tgt", i), pc_target, vec[i].exp_tgt);
      if (vec[i].chk_top) chk($sformatf("vec%0d_top", i), stack_top, vec[i].exp_top);
      adv();
    end

    // Asynchronous reset in the middle of a CALL
    drive(1'b1, 14'h2100, 1'b0, 1'b0, 10'h055);
    chk("rst_fetch_en", en_act, 7'b1000000);
    adv();
    drive(1'b0, '0, 1'b0, 1'b0, 10'h055);
    chk("rst_exec_en", en_act, 7'b0101000);
    reset = 1'b1;
    #1;
    chk("rst_async_en", en_act, 7'b1000000);
    chk("rst_async_tgt", pc_target, 10'h000);
    adv();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    chk("rst_after_en", en_act, 7'b1000000);

    // RETLW 0x7F at reset depth
    drive(1'b1, 14'h347F, 1'b0, 1'b0, '0);
    adv();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
`ifdef STACK_TRAP_EN
    chk("retlw0_en", en_act, 7'b0110001);
    chk("retlw0_tgt", pc_target, 10'h000);
`else
    chk("retlw0_en", en_act, 7'b0100101);
    chk("retlw0_tgt", pc_target, 10'h07F);
`endif
    chk("retlw0_err_pre", stack_err, 1'b0);
    adv();
    chk("retlw0_flush_en", en_act, 7'b0000000);
`ifdef STACK_TRAP_EN
    chk("retlw0_err", stack_err, 1'b1);
`else
    chk("retlw0_err", stack_err, 1'b0);
`endif
    adv();
    reset = 1'b1;
    #1;
    chk("rst2_err", stack_err, 1'b0);
    adv();
    reset = 1'b0;

    // 9 CALLs then 8 RETURNs: the 9th push overwrites the oldest entry
    for (int k = 1; k <= 8; k++) do_call(10'(k * 16), 10'(k));
    chk("deep8_err", stack_err, 1'b0);
    do_call(10'h090, 10'h009);
`ifdef STACK_TRAP_EN
    chk("deep9_err", stack_err, 1'b1);
`else
    chk("deep9_err", stack_err, 1'b0);
`endif
    for (int k = 0; k < 8; k++) do_ret(10'(9 - k));

    // Two underflowing RETLWs; the second wraps sp from 0 to 7
    drive(1'b1, 14'h347F, 1'b0, 1'b0, '0);
    adv();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
`ifdef STACK_TRAP_EN
    chk("uf1_en", en_act, 7'b0110001);
`else
    chk("uf1_en", en_act, 7'b0100101);
`endif
    chk("uf1_top", stack_top, 10'h009);
    adv();
    chk("uf1_flush_en", en_act, 7'b0000000);
`ifndef STACK_TRAP_EN
    chk("uf1_flush_top", stack_top, 10'h008);
`endif
    adv();
    drive(1'b1, 14'h3455, 1'b0, 1'b0, '0);
    adv();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
`ifdef STACK_TRAP_EN
    chk("uf2_en", en_act, 7'b0110001);
    chk("uf2_tgt", pc_target, 10'h000);
    chk("uf2_err", stack_err, 1'b1);
`else
    chk("uf2_en", en_act, 7'b0100101);
    chk("uf2_tgt", pc_target, 10'h055);
    chk("uf2_top", stack_top, 10'h008);
`endif
    adv();
    chk("uf2_flush_en", en_act, 7'b0000000);
`ifndef STACK_TRAP_EN
    chk("uf2_wrap_top", stack_top, 10'h007);
`endif
    adv();
    chk("final_fetch_en", en_act, 7'b1000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
